// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default parameters for the fetch unit
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, PAUSE} fetch_state_t;
  localparam int ADDR_W_DEF   = 16;
  localparam int INSTR_W_DEF  = 16;
  localparam int PC_STEP_DEF  = 16;
  localparam int RESET_PC_DEF = 0;
  localparam int CNT_W_DEF    = 16;
endpackage

// File: rtl/multicycle_fetch_unit_if.sv
// multicycle_fetch_unit_if: instruction-memory request and downstream instruction handshakes
interface multicycle_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/multicycle_fetch_unit_pc_adder.sv
// pc_adder: sequential PC successor, wrapping modulo 2^ADDR_W
module pc_adder #(
  parameter int ADDR_W  = 16,
  parameter int PC_STEP = 16
) (
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] sum_o
);
  assign sum_o = pc_i + ADDR_W'(PC_STEP);
endmodule

// File: rtl/multicycle_fetch_unit.sv
// multicycle_fetch_unit: PC owner, imem req/ack fetch, valid/ready issue, stall and redirect
module multicycle_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int PC_STEP  = PC_STEP_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_W-1:0]      redirect_pc_i,
  multicycle_fetch_unit_if.master bus,
  output logic [ADDR_W-1:0]      pc_o,
  output logic [CNT_W-1:0]       fetch_count_o,
  output logic                   busy_o
);
  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, ipc_q, ipc_d, tgt_q, tgt_d, pc_next;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  pc_adder #(.ADDR_W(ADDR_W), .PC_STEP(PC_STEP)) u_pc_adder (.pc_i(pc_q), .sum_o(pc_next));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ipc_q   <= '0;
      tgt_q   <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d    = redirect_valid_i ? redirect_pc_i : pc_q;
        state_d = !start_i ? IDLE : stall_i ? PAUSE : FETCH;
      end
      FETCH: begin
        if (bus.imem_ack && redirect_valid_i) pc_d = redirect_pc_i;
        else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          state_d = HOLD;
        end else if (redirect_valid_i) begin
          tgt_d   = redirect_pc_i;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The in-flight response belongs to the abandoned path; only its ack matters
        tgt_d = redirect_valid_i ? redirect_pc_i : tgt_q;
        if (bus.imem_ack) begin
          pc_d    = redirect_valid_i ? redirect_pc_i : tgt_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (bus.instr_ready || redirect_valid_i) begin
          cnt_d   = bus.instr_ready ? cnt_q + CNT_W'(1) : cnt_q;
          pc_d    = redirect_valid_i ? redirect_pc_i : pc_next;
          state_d = stall_i ? PAUSE : FETCH;
        end
      end
      PAUSE: begin
        pc_d    = redirect_valid_i ? redirect_pc_i : pc_q;
        state_d = stall_i ? PAUSE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = state_q == HOLD;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign pc_o            = pc_q;
  assign fetch_count_o   = cnt_q;
  assign busy_o          = state_q != IDLE;
endmodule

// File: tb/tb_multicycle_fetch_unit.sv
// tb_multicycle_fetch_unit: directed scenarios plus randomized run against a path-level model
module tb_multicycle_fetch_unit;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic        start = 0, stall = 0, rv = 0, busy;
  logic [15:0] rpc = '0, pc, cnt;
  logic        start8 = 0, stall8 = 0, rv8 = 0, busy8;
  logic [7:0]  rpc8 = '0, pc8;
  logic [15:0] cnt8;

  multicycle_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) ifc ();
  multicycle_fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) ifc8 ();

  multicycle_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_STEP(16), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_pc_i(rpc), .bus(ifc.master), .pc_o(pc), .fetch_count_o(cnt), .busy_o(busy));

  multicycle_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .PC_STEP(16), .RESET_PC(8'hF0), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .stall_i(stall8), .redirect_valid_i(rv8),
    .redirect_pc_i(rpc8), .bus(ifc8.master), .pc_o(pc8), .fetch_count_o(cnt8), .busy_o(busy8));

  function automatic logic [15:0] mem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!ifc.imem_req && n < 20) begin step(); n++; end
    checks++;
    if (!ifc.imem_req) begin errors++; $display("FAIL %s: no imem_req within 20 cycles", tag); end
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (pc !== 0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (ifc.imem_req !== 0 || ifc.instr_valid !== 0) begin errors++; $display("FAIL reset_req_valid: got %b%b want 00", ifc.imem_req, ifc.instr_valid); end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    checks++; if (ifc.instr_out !== 0 || ifc.instr_pc !== 0) begin errors++; $display("FAIL reset_instr: got %h/%h want 0/0", ifc.instr_out, ifc.instr_pc); end
    checks++; if (pc8 !== 8'hF0) begin errors++; $display("FAIL reset_pc8: got %h want f0", pc8); end
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    start = 1; ifc.instr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      exp = 16'(i * 16);
      wait_req("basic_req");
      checks++; if (ifc.imem_addr !== exp) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, ifc.imem_addr, exp); end
      ifc.imem_ack = 1; ifc.imem_rdata = mem(ifc.imem_addr); step(); ifc.imem_ack = 0;
      checks++; if (ifc.instr_valid !== 1) begin errors++; $display("FAIL basic_valid%0d: got %b want 1", i, ifc.instr_valid); end
      checks++; if (ifc.instr_pc !== exp || ifc.instr_out !== mem(exp)) begin errors++; $display("FAIL basic_instr%0d: got %h@%h want %h@%h", i, ifc.instr_out, ifc.instr_pc, mem(exp), exp); end
      step();
    end
    checks++; if (cnt !== 3) begin errors++; $display("FAIL basic_cnt: got %0d want 3", cnt); end
  endtask

  task automatic test_hold_stall();
    ifc.instr_ready = 0;
    wait_req("hold_req");
    ifc.imem_ack = 1; ifc.imem_rdata = mem(16'd48); step(); ifc.imem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ifc.instr_valid !== 1 || ifc.instr_pc !== 16'd48 || ifc.instr_out !== mem(16'd48) || ifc.imem_req !== 0 || cnt !== 3) begin
        errors++; $display("FAIL hold_stable%0d: got v=%b %h@%h req=%b cnt=%0d want v=1 %h@0030 req=0 cnt=3", i, ifc.instr_valid, ifc.instr_out, ifc.instr_pc, ifc.imem_req, cnt, mem(16'd48));
      end
      step();
    end
    ifc.instr_ready = 1; step();
    checks++; if (cnt !== 4) begin errors++; $display("FAIL hold_cnt: got %0d want 4", cnt); end
  endtask

  task automatic test_drain();
    ifc.instr_ready = 0;
    checks++; if (ifc.imem_req !== 1 || ifc.imem_addr !== 16'd64) begin errors++; $display("FAIL drain_pre: got req=%b addr=%h want 1/0040", ifc.imem_req, ifc.imem_addr); end
    rv = 1; rpc = 16'h0100; step(); rv = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ifc.imem_req !== 1 || ifc.imem_addr !== 16'd64) begin errors++; $display("FAIL drain_hold%0d: got req=%b addr=%h want 1/0040", i, ifc.imem_req, ifc.imem_addr); end
      step();
    end
    ifc.imem_ack = 1; ifc.imem_rdata = 16'hDEAD; step(); ifc.imem_ack = 0;
    checks++; if (ifc.imem_req !== 1 || ifc.imem_addr !== 16'h0100 || ifc.instr_valid !== 0) begin errors++; $display("FAIL drain_redir: got req=%b addr=%h v=%b want 1/0100/0", ifc.imem_req, ifc.imem_addr, ifc.instr_valid); end
    ifc.imem_ack = 1; ifc.imem_rdata = mem(16'h0100); step(); ifc.imem_ack = 0;
    checks++; if (ifc.instr_valid !== 1 || ifc.instr_pc !== 16'h0100 || ifc.instr_out !== mem(16'h0100)) begin errors++; $display("FAIL drain_instr: got v=%b %h@%h want 1 %h@0100", ifc.instr_valid, ifc.instr_out, ifc.instr_pc, mem(16'h0100)); end
  endtask

  task automatic test_hold_redirect();
    rv = 1; rpc = 16'h0040; ifc.instr_ready = 1; step(); rv = 0;
    checks++; if (cnt !== 5) begin errors++; $display("FAIL hredir_cnt: got %0d want 5", cnt); end
    checks++; if (ifc.imem_req !== 1 || ifc.imem_addr !== 16'h0040) begin errors++; $display("FAIL hredir_addr: got req=%b addr=%h want 1/0040", ifc.imem_req, ifc.imem_addr); end
  endtask

  task automatic test_wrap8();
    int n = 0;
    start8 = 1; ifc8.instr_ready = 0; ifc8.imem_ack = 0;
    while (!ifc8.imem_req && n < 20) begin step(); n++; end
    checks++; if (ifc8.imem_req !== 1 || ifc8.imem_addr !== 8'hF0) begin errors++; $display("FAIL wrap_req: got req=%b addr=%h want 1/f0", ifc8.imem_req, ifc8.imem_addr); end
    ifc8.imem_ack = 1; ifc8.imem_rdata = mem(16'h00F0); step(); ifc8.imem_ack = 0;
    checks++; if (ifc8.instr_valid !== 1 || ifc8.instr_pc !== 8'hF0) begin errors++; $display("FAIL wrap_valid: got v=%b pc=%h want 1/f0", ifc8.instr_valid, ifc8.instr_pc); end
    ifc8.instr_ready = 1; stall8 = 1; step();
    checks++; if (pc8 !== 8'h00 || busy8 !== 1) begin errors++; $display("FAIL wrap_pc: got pc=%h busy=%b want 00/1", pc8, busy8); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifc8.imem_req !== 0 || ifc8.instr_valid !== 0) begin errors++; $display("FAIL wrap_pause%0d: got req=%b v=%b want 0/0", i, ifc8.imem_req, ifc8.instr_valid); end
      step();
    end
    stall8 = 0; step();
    checks++; if (ifc8.imem_req !== 1 || ifc8.imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_resume: got req=%b addr=%h want 1/00", ifc8.imem_req, ifc8.imem_addr); end
    checks++; if (cnt8 !== 1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", cnt8); end
    start8 = 0;
  endtask

  task automatic test_reset_mid();
    ifc.instr_ready = 0;
    wait_req("rmid_req");
    rst = 1; step(); rst = 0;
    checks++; if (busy !== 0 || pc !== 0 || ifc.imem_req !== 0 || ifc.instr_valid !== 0 || cnt !== 0) begin errors++; $display("FAIL rst_fetch: got busy=%b pc=%h req=%b v=%b cnt=%0d want 0", busy, pc, ifc.imem_req, ifc.instr_valid, cnt); end
    wait_req("rmid_req2");
    ifc.imem_ack = 1; ifc.imem_rdata = mem(16'h0); step(); ifc.imem_ack = 0;
    checks++; if (ifc.instr_valid !== 1) begin errors++; $display("FAIL rst_prehold: got v=%b want 1", ifc.instr_valid); end
    ifc.instr_ready = 1; rst = 1; step(); rst = 0;
    checks++; if (busy !== 0 || pc !== 0 || ifc.imem_req !== 0 || ifc.instr_valid !== 0 || cnt !== 0) begin errors++; $display("FAIL rst_hold: got busy=%b pc=%h req=%b v=%b cnt=%0d want 0", busy, pc, ifc.imem_req, ifc.instr_valid, cnt); end
  endtask

  // Model: every accepted instruction sits on the path set by the latest redirect,
  // advancing by 16 per accepted instruction; memory content is a fixed function of address.
  task automatic test_random();
    logic [15:0] exp = 16'h0, paddr = 16'h0;
    int acc = 0;
    logic pend = 0;
    rv = 0; rst = 1; step(); rst = 0; start = 1;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3) == 0);
      ifc.instr_ready = $urandom_range(1);
      rv = ($urandom_range(7) == 0);
      rpc = 16'($urandom) & 16'hFFF0;
      ifc.imem_ack = ifc.imem_req && ($urandom_range(2) == 0);
      ifc.imem_rdata = ifc.imem_ack ? mem(ifc.imem_addr) : 16'($urandom);
      if (pend) begin
        checks++; if (ifc.imem_req !== 1 || ifc.imem_addr !== paddr) begin errors++; $display("FAIL rnd_req_held@%0d: got req=%b addr=%h want 1/%h", i, ifc.imem_req, ifc.imem_addr, paddr); end
      end
      checks++; if (ifc.imem_req && ifc.instr_valid) begin errors++; $display("FAIL rnd_excl@%0d: got req=1 valid=1 want not both", i); end
      if (ifc.instr_valid && ifc.instr_ready) begin
        checks++;
        if (ifc.instr_pc !== exp || ifc.instr_out !== mem(exp)) begin errors++; $display("FAIL rnd_instr@%0d: got %h@%h want %h@%h", i, ifc.instr_out, ifc.instr_pc, mem(exp), exp); end
        exp = rv ? rpc : exp + 16'd16;
        acc++;
      end else if (rv) exp = rpc;
      pend = ifc.imem_req && !ifc.imem_ack;
      paddr = ifc.imem_addr;
      step();
    end
    checks++; if (cnt !== 16'(acc)) begin errors++; $display("FAIL rnd_cnt: got %0d want %0d", cnt, 16'(acc)); end
    checks++; if (acc < 50) begin errors++; $display("FAIL rnd_progress: got %0d accepts want >= 50", acc); end
    rv = 0; stall = 0; ifc.imem_ack = 0;
  endtask

  initial begin
    ifc.imem_ack = 0; ifc.imem_rdata = '0; ifc.instr_ready = 0;
    ifc8.imem_ack = 0; ifc8.imem_rdata = '0; ifc8.instr_ready = 0;
    step();
    test_reset();
    test_basic();
    test_hold_stall();
    test_drain();
    test_hold_redirect();
    test_wrap8();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
